// File: rtl/rv_mdu_pkg.sv
// Shared definitions for the RV32/64 M-extension multiply/divide unit.
package rv_mdu_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Bits needed to count 0 .. n-1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned v;
        int unsigned w;
        v = n - 1;
        w = 0;
        while (v != 0) begin
            v = v >> 1;
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's complement of a W-bit value.
module mdu_negate #(
    parameter int unsigned W = 32
) (
    input  logic         i_en,
    input  logic [W-1:0] i_val,
    output logic [W-1:0] o_val_c
);

    assign o_val_c = i_en ? W'(~i_val + W'(1)) : i_val;

endmodule

// File: rtl/rv_mdu.sv
// Iterative radix-2 multiply/divide unit: shift-add multiply, restoring divide,
// sign handled by magnitude conversion up front and correction in FIX.
module rv_mdu
    import rv_mdu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] r
);

    localparam int unsigned CNT_W = clog2(XLEN);
    localparam int unsigned DW    = 2 * XLEN;

    state_e            r_state;
    state_e            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [DW-1:0]     r_acc;
    logic [XLEN-1:0]   r_opb;
    logic [2:0]        r_op;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [XLEN-1:0]   r_res;
    logic              r_busy;
    logic              r_done;

    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_sa;
    logic              w_sb;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic              w_div0;
    logic              w_ovf;
    logic              w_special;
    logic              w_accept;
    logic [XLEN:0]     w_mul_sum;
    logic [DW-1:0]     w_mul_step;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN:0]     w_diff;
    logic [DW-1:0]     w_div_step;
    logic [DW-1:0]     w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_result;

    // Operand sign decode and special-case detection at request time.
    assign w_a_signed = (op == OP_MULH) | (op == OP_MULHSU) | (op == OP_DIV) | (op == OP_REM);
    assign w_b_signed = (op == OP_MULH) | (op == OP_DIV) | (op == OP_REM);
    assign w_sa       = w_a_signed & a[XLEN-1];
    assign w_sb       = w_b_signed & b[XLEN-1];
    assign w_div0     = op[2] & (b == '0);
    assign w_ovf      = op[2] & ~op[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (&b);
    assign w_special  = w_div0 | w_ovf;
    assign w_accept   = start & ~kill & ((r_state == ST_IDLE) | (r_state == ST_DONE));

    mdu_negate #(.W(XLEN)) u_neg_a (.i_en(w_sa), .i_val(a), .o_val_c(w_mag_a));
    mdu_negate #(.W(XLEN)) u_neg_b (.i_en(w_sb), .i_val(b), .o_val_c(w_mag_b));

    // One multiply step: add multiplier into high half when LSB set, shift right.
    assign w_mul_sum  = {1'b0, r_acc[DW-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    assign w_mul_step = {w_mul_sum, r_acc[XLEN-1:1]};

    // One restoring divide step: remainder in high half, quotient shifts into low half.
    assign w_rem_sh   = r_acc[DW-1:XLEN-1];
    assign w_diff     = w_rem_sh - {1'b0, r_opb};
    assign w_div_step = w_diff[XLEN] ? {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                     : {w_diff[XLEN-1:0],   r_acc[XLEN-2:0], 1'b1};

    mdu_negate #(.W(DW))   u_neg_p (.i_en(r_neg_q), .i_val(r_acc),              .o_val_c(w_prod));
    mdu_negate #(.W(XLEN)) u_neg_q (.i_en(r_neg_q), .i_val(r_acc[XLEN-1:0]),    .o_val_c(w_quot));
    mdu_negate #(.W(XLEN)) u_neg_r (.i_en(r_neg_r), .i_val(r_acc[DW-1:XLEN]),   .o_val_c(w_rem));

    always_comb begin
        w_result = w_prod[XLEN-1:0];
        case (r_op)
            OP_MUL:                       w_result = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_result = w_prod[DW-1:XLEN];
            OP_DIV, OP_DIVU:              w_result = w_quot;
            OP_REM, OP_REMU:              w_result = w_rem;
            default:                      w_result = w_prod[XLEN-1:0];
        endcase
    end

    // Next-state logic; kill overrides every transition.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_next = ST_IDLE;
                if (start) w_next = w_special ? ST_FIX : ST_CALC;
            end
            ST_CALC: if (r_cnt == CNT_W'(XLEN - 1)) w_next = ST_FIX;
            ST_FIX:  w_next = ST_DONE;
            default: w_next = ST_IDLE;
        endcase
        if (kill) w_next = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_opb   <= '0;
            r_op    <= OP_MUL;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_res   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == ST_CALC) | (w_next == ST_FIX);
            r_done  <= (w_next == ST_DONE);
            if (w_accept) begin
                r_op  <= op;
                r_cnt <= '0;
                r_opb <= w_mag_b;
                // Special cases preload the final fields so FIX passes them through.
                if (w_div0) begin
                    r_acc   <= {a, {XLEN{1'b1}}};
                    r_neg_q <= 1'b0;
                    r_neg_r <= 1'b0;
                end else if (w_ovf) begin
                    r_acc   <= {{XLEN{1'b0}}, a};
                    r_neg_q <= 1'b0;
                    r_neg_r <= 1'b0;
                end else begin
                    r_acc   <= {{XLEN{1'b0}}, w_mag_a};
                    r_neg_q <= w_sa ^ w_sb;
                    r_neg_r <= w_sa;
                end
            end else if ((r_state == ST_CALC) && !kill) begin
                r_cnt <= r_cnt + CNT_W'(1);
                r_acc <= r_op[2] ? w_div_step : w_mul_step;
            end
            if ((r_state == ST_FIX) && !kill) r_res <= w_result;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign r    = r_res;

endmodule

// File: doc/rv_mdu.md
RV_MDU -- requirements
Module: rv_mdu

Interface
REQ-001 Parameter XLEN, default 32: operand and result width; legal values 8, 16, 32, 64.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  request; sampled only when busy=0.
REQ-005 kill  in  1  synchronous abort of any operation in flight.
REQ-006 op  in  3  RV M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 a  in  XLEN  rs1 operand (multiplicand / dividend).
REQ-008 b  in  XLEN  rs2 operand (multiplier / divisor).
REQ-009 busy  out  1  high while an operation is in flight.
REQ-010 done  out  1  one-cycle pulse; r is valid in that cycle.
REQ-011 r  out  XLEN  result, registered.

Function
REQ-012 States: IDLE, CALC, FIX, DONE; busy=1 exactly in CALC and FIX.
REQ-013 IDLE or DONE, start=1, kill=0: latch op, a, b; go to CALC with iteration counter 0; a special case (REQ-019, REQ-020) goes to FIX instead.
REQ-014 Before iterating, signed operands are replaced by their magnitude; operand and result signs are recorded.
REQ-015 Signed operands: a for MULH, MULHSU, DIV, REM; b for MULH, DIV, REM only.
REQ-016 CALC: one radix-2 step per cycle, shift-add for multiply, restoring shift-subtract for divide; exactly XLEN cycles; counter wraps XLEN-1 -> FIX.
REQ-017 FIX: one cycle; conditionally negate the 2*XLEN product, quotient or remainder; select the result field; register it into r.
REQ-018 Result field: MUL takes the product low half; MULH/MULHSU/MULHU take the high half. Quotient sign = sign(a) xor sign(b). Remainder sign = sign(a).
REQ-019 Divide by zero (b=0, DIV/DIVU/REM/REMU): quotient all ones; remainder = a; skip CALC.
REQ-020 Signed overflow (DIV/REM, a = most negative, b = all ones): quotient = a; remainder = 0; skip CALC.
REQ-021 DONE: done=1 for one cycle, then IDLE, unless a new start is accepted in that cycle.
REQ-022 Latency, start-sampling edge to done cycle: XLEN+2 cycles normally; 2 cycles for REQ-019/REQ-020.
REQ-023 r holds its value from FIX until the next FIX; it does not change on start or kill.
REQ-024 start while busy=1: ignored, no queuing.
REQ-025 kill=1 in any state: IDLE at the next edge, no done pulse, r unchanged.
REQ-026 kill and start together: kill wins; start is dropped.
REQ-027 Input changes during CALC/FIX do not affect the result.

Reset
REQ-028 rst=1 at an edge: state IDLE, busy=0, done=0, r=0, counter=0, in any state including mid-CALC.
REQ-029 rst has priority over kill and start.

Structure
REQ-030 Shared package rv_mdu_pkg holds the op encodings, the state enumeration and the counter-width function clog2(XLEN).
REQ-031 One sub-module, mdu_negate (parametrised width, conditional two's complement), is instantiated for operand magnitude and for result correction.
REQ-032 Datapath is one 2*XLEN accumulator/remainder register and one XLEN operand register; there are no XLEN-wide multipliers or dividers.

Verification
REQ-033 Bench runs at XLEN=32 and XLEN=8.
REQ-034 MUL a=7, b=0xFFFFFFFD -> r=0xFFFFFFEB; done 34 cycles after the start edge; busy high for 33 cycles.
REQ-035 High-half multiplies:
- MULH 0x80000000 x 0x80000000 -> 0x40000000.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-036 Signed divide with negative dividend:
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
- REM 0xFFFFFFF9 / 2 -> 0xFFFFFFFF.
- DIVU 100 / 7 -> 14.
- REMU 100 / 7 -> 2.
REQ-037 Special cases, each with done 2 cycles after start:
- DIVU 5 / 0 -> 0xFFFFFFFF.
- REMU 5 / 0 -> 5.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
- REM of the same operands -> 0.
REQ-038 kill in the 10th CALC cycle -> no done, busy=0 next cycle, r unchanged; a new start next cycle completes correctly.
REQ-039 rst during CALC -> busy=0, done=0, r=0 after the edge.
REQ-040 start pulsed during busy -> ignored.
REQ-041 start in the DONE cycle -> back-to-back operation accepted.
